// File: rtl/rbus_demux1to2.sv
// Store-and-forward 1-to-2 rbus packet router with a 32-word FIFO and space reservation.
// Optional protocol checking is enabled by defining RBUS_DEMUX1TO2_PROTO_CHECK_EN.
module rbus_demux1to2 #(
  parameter int unsigned SEL_BIT = 38
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic        i_sof,
  input  logic [71:0] i_data,
  output logic [1:0]  i_rdy,
  output logic        oa_stb,
  output logic        oa_sof,
  output logic [71:0] oa_data,
  input  logic [1:0]  oa_rdy,
  output logic        ob_stb,
  output logic        ob_sof,
  output logic [71:0] ob_data,
  input  logic [1:0]  ob_rdy,
  output logic        ff_err
);
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned LEN_BIT = 39;
  localparam logic [3:0]  LONG_LEN  = 4'd9;
  localparam logic [3:0]  SHORT_LEN = 4'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_DECIDE, ST_WAIT, ST_SEND} state_t;

  logic [71:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_n, wr_addr, rd_ptr;
  logic [3:0]    wr_cnt, wr_cnt_n, rd_left;
  logic [5:0]    occ, occ_wr;
  logic [4:0]    pkt_cnt;
  logic [6:0]    fill;
  logic          wr_en, pkt_inc, pkt_dec, err_set, drop;
  state_t        state;
  logic          first, sel_dest, sel_long;
  logic [71:0]   head;
  logic          head_dest, head_long, head_ok, wait_ok;
  logic [1:0]    head_rdy, wait_rdy;
  logic          pop, pop_dest, pop_sof;
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
  logic [3:0]    pkt_words, pkt_words_n;
  logic          viol;
`endif

  // Write side: header reservation, word counting, truncation rewind and overflow
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = wr_ptr;
    wr_ptr_n = wr_ptr;
    wr_cnt_n = wr_cnt;
    occ_wr   = occ;
    pkt_inc  = 1'b0;
    err_set  = 1'b0;
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
    pkt_words_n = pkt_words;
    drop = i_stb & ~i_sof & (wr_cnt == 4'd0);
    viol = i_stb & i_sof & (wr_cnt != 4'd0);
`else
    drop = 1'b0;
`endif
    if (i_stb && !drop) begin
      if (occ == 6'(DEPTH)) begin
        err_set = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (i_sof) begin
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
          // Discard any partial packet so the FIFO only ever holds whole packets
          wr_addr     = wr_ptr - AW'(pkt_words);
          occ_wr      = occ - 6'(pkt_words);
          pkt_words_n = 4'd1;
`endif
          wr_ptr_n = wr_addr + 5'd1;
          wr_cnt_n = (i_data[LEN_BIT] ? LONG_LEN : SHORT_LEN) - 4'd1;
          occ_wr   = occ_wr + 6'd1;
        end else begin
          wr_ptr_n = wr_ptr + 5'd1;
          occ_wr   = occ + 6'd1;
          if (wr_cnt != 4'd0) begin
            wr_cnt_n = wr_cnt - 4'd1;
            pkt_inc  = (wr_cnt == 4'd1);
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
            pkt_words_n = (wr_cnt == 4'd1) ? 4'd0 : pkt_words + 4'd1;
`endif
          end
        end
      end
    end
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
    if (drop || viol) err_set = 1'b1;
`endif
  end

  // Remaining word count of the in-flight packet is exactly its reservation
  assign fill = 7'(occ) + 7'(wr_cnt);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_cnt  <= '0;
      occ     <= '0;
      pkt_cnt <= '0;
      i_rdy   <= 2'b00;
      ff_err  <= 1'b0;
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
      pkt_words <= '0;
`endif
    end else begin
      wr_ptr  <= wr_ptr_n;
      wr_cnt  <= wr_cnt_n;
      occ     <= occ_wr - 6'(pop);
      pkt_cnt <= pkt_cnt + 5'(pkt_inc) - 5'(pkt_dec);
      i_rdy   <= {fill <= 7'd14, fill <= 7'd21};
      ff_err  <= ff_err | err_set;
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
      pkt_words <= pkt_words_n;
`endif
    end
  end

  // Head-of-FIFO decode and pop control shared by occupancy and the read FSM
  always_comb begin
    head      = mem[rd_ptr];
    head_dest = head[SEL_BIT];
    head_long = head[LEN_BIT];
    head_rdy  = head_dest ? ob_rdy : oa_rdy;
    head_ok   = head_long ? head_rdy[1] : head_rdy[0];
    wait_rdy  = sel_dest ? ob_rdy : oa_rdy;
    wait_ok   = sel_long ? wait_rdy[1] : wait_rdy[0];
    pkt_dec   = (state == ST_DECIDE);
    pop       = ((state == ST_DECIDE) && head_ok) || (state == ST_SEND);
    pop_dest  = (state == ST_DECIDE) ? head_dest : sel_dest;
    pop_sof   = (state == ST_DECIDE) || first;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rd_ptr   <= '0;
      rd_left  <= '0;
      first    <= 1'b0;
      sel_dest <= 1'b0;
      sel_long <= 1'b0;
      oa_stb   <= 1'b0;
      oa_sof   <= 1'b0;
      oa_data  <= '0;
      ob_stb   <= 1'b0;
      ob_sof   <= 1'b0;
      ob_data  <= '0;
    end else begin
      oa_stb <= 1'b0;
      oa_sof <= 1'b0;
      ob_stb <= 1'b0;
      ob_sof <= 1'b0;
      if (pop) begin
        rd_ptr <= rd_ptr + 5'd1;
        if (pop_dest) begin
          ob_stb  <= 1'b1;
          ob_sof  <= pop_sof;
          ob_data <= head;
        end else begin
          oa_stb  <= 1'b1;
          oa_sof  <= pop_sof;
          oa_data <= head;
        end
      end
      case (state)
        ST_IDLE: if (pkt_cnt != 5'd0) state <= ST_DECIDE;
        ST_DECIDE: begin
          sel_dest <= head_dest;
          sel_long <= head_long;
          // Ready target: header leaves now; otherwise hold the whole packet in WAIT
          if (head_ok) begin
            rd_left <= (head_long ? LONG_LEN : SHORT_LEN) - 4'd1;
            first   <= 1'b0;
            state   <= ST_SEND;
          end else begin
            rd_left <= head_long ? LONG_LEN : SHORT_LEN;
            first   <= 1'b1;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: if (wait_ok) state <= ST_SEND;
        ST_SEND: begin
          first   <= 1'b0;
          rd_left <= rd_left - 4'd1;
          if (rd_left == 4'd1) state <= (pkt_cnt != 5'd0) ? ST_DECIDE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rbus_demux1to2.sv
// Directed self-checking bench for rbus_demux1to2.
module tb_rbus_demux1to2;
  logic        clk, rst;
  logic        i_stb, i_sof;
  logic [71:0] i_data;
  logic [1:0]  i_rdy, oa_rdy, ob_rdy;
  logic        oa_stb, oa_sof, ob_stb, ob_sof, ff_err;
  logic [71:0] oa_data, ob_data;

  typedef struct packed {
    logic [31:0] cyc;
    logic        sof;
    logic [71:0] data;
  } word_t;

  word_t qa[$], qb[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  rbus_demux1to2 #(.SEL_BIT(38)) dut (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data), .i_rdy(i_rdy),
    .oa_stb(oa_stb), .oa_sof(oa_sof), .oa_data(oa_data), .oa_rdy(oa_rdy),
    .ob_stb(ob_stb), .ob_sof(ob_sof), .ob_data(ob_data), .ob_rdy(ob_rdy),
    .ff_err(ff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted word with its cycle number for order and gap checks
  always @(negedge clk) begin
    if (oa_stb === 1'b1) qa.push_back('{32'(cyc), oa_sof, oa_data});
    if (ob_stb === 1'b1) qb.push_back('{32'(cyc), ob_sof, ob_data});
  end

  function automatic logic [71:0] hdr(input logic lng, input logic dst, input logic [15:0] tag);
    return {16'hCAFE, tag, lng, dst, 38'h0};
  endfunction

  function automatic logic [71:0] pay(input logic [15:0] tag, input int i);
    return {16'hBEEF, tag, 40'(i)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic lng, input logic dst, input logic [15:0] tag);
    int n;
    n = lng ? 9 : 2;
    i_stb = 1'b1; i_sof = 1'b1; i_data = hdr(lng, dst, tag);
    tick;
    for (int i = 1; i < n; i++) begin
      i_sof = 1'b0; i_data = pay(tag, i);
      tick;
    end
    i_stb = 1'b0; i_sof = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_stb = 1'b0; i_sof = 1'b0; i_data = '0; oa_rdy = 2'b00; ob_rdy = 2'b00;
    repeat (3) tick;
    checks++;
    if ({oa_stb, ob_stb, oa_sof, ob_sof, ff_err, i_rdy} !== 7'b0)
      begin failures++; $display("FAIL reset_flags got=%b exp=0000000", {oa_stb, ob_stb, oa_sof, ob_sof, ff_err, i_rdy}); end
    checks++;
    if (oa_data !== 72'h0 || ob_data !== 72'h0)
      begin failures++; $display("FAIL reset_data got a=%h b=%h exp=0", oa_data, ob_data); end
    rst = 1'b0;
    #1;
    checks++;
    if (i_rdy !== 2'b00) begin failures++; $display("FAIL rdy_after_release got=%b exp=00", i_rdy); end
    tick;
    checks++;
    if (i_rdy !== 2'b11) begin failures++; $display("FAIL rdy_second_cycle got=%b exp=11", i_rdy); end
  endtask

  task automatic test_short_a;
    logic b_seen;
    oa_rdy = 2'b11; ob_rdy = 2'b00;
    send_pkt(1'b0, 1'b0, 16'h0001);
    tick;
    b_seen = ob_stb;
    checks++;
    if (oa_stb !== 1'b0) begin failures++; $display("FAIL short_early got stb=%b exp=0", oa_stb); end
    tick;
    b_seen |= ob_stb;
    checks++;
    if (oa_stb !== 1'b1 || oa_sof !== 1'b1 || oa_data !== hdr(1'b0, 1'b0, 16'h0001))
      begin failures++; $display("FAIL short_hdr got stb=%b sof=%b d=%h exp=1 1 %h", oa_stb, oa_sof, oa_data, hdr(1'b0, 1'b0, 16'h0001)); end
    tick;
    b_seen |= ob_stb;
    checks++;
    if (oa_stb !== 1'b1 || oa_sof !== 1'b0 || oa_data !== pay(16'h0001, 1))
      begin failures++; $display("FAIL short_pay got stb=%b sof=%b d=%h exp=1 0 %h", oa_stb, oa_sof, oa_data, pay(16'h0001, 1)); end
    tick;
    b_seen |= ob_stb;
    checks++;
    if (oa_stb !== 1'b0 || oa_data !== pay(16'h0001, 1))
      begin failures++; $display("FAIL short_end got stb=%b d=%h exp=0 %h", oa_stb, oa_data, pay(16'h0001, 1)); end
    checks++;
    if (b_seen !== 1'b0 || ff_err !== 1'b0)
      begin failures++; $display("FAIL short_b_idle got ob_stb_seen=%b ff_err=%b exp=0 0", b_seen, ff_err); end
  endtask

  task automatic test_wait_b;
    logic seen;
    oa_rdy = 2'b11; ob_rdy = 2'b01;
    qa.delete(); qb.delete();
    send_pkt(1'b1, 1'b1, 16'h0002);
    seen = 1'b0;
    repeat (20) begin tick; seen |= ob_stb; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL wait_held got ob_stb_seen=%b exp=0", seen); end
    ob_rdy = 2'b11;
    tick;
    checks++;
    if (ob_stb !== 1'b0) begin failures++; $display("FAIL wait_to_send got stb=%b exp=0", ob_stb); end
    tick;
    checks++;
    if (ob_stb !== 1'b1 || ob_sof !== 1'b1 || ob_data !== hdr(1'b1, 1'b1, 16'h0002))
      begin failures++; $display("FAIL wait_hdr got stb=%b sof=%b d=%h exp=1 1 %h", ob_stb, ob_sof, ob_data, hdr(1'b1, 1'b1, 16'h0002)); end
    for (int i = 1; i < 9; i++) begin
      tick;
      checks++;
      if (ob_stb !== 1'b1 || ob_sof !== 1'b0 || ob_data !== pay(16'h0002, i))
        begin failures++; $display("FAIL wait_word%0d got stb=%b sof=%b d=%h exp=1 0 %h", i, ob_stb, ob_sof, ob_data, pay(16'h0002, i)); end
    end
    tick;
    checks++;
    if (ob_stb !== 1'b0 || qa.size() != 0)
      begin failures++; $display("FAIL wait_end got ob_stb=%b a_words=%0d exp=0 0", ob_stb, qa.size()); end
  endtask

  task automatic test_fill_drain;
    int ia, ib, pk, wi, c0;
    logic dst;
    logic [15:0] tag;
    logic [71:0] exp_d;
    word_t w;
    oa_rdy = 2'b00; ob_rdy = 2'b00;
    qa.delete(); qb.delete();
    send_pkt(1'b1, 1'b0, 16'h0003);
    checks++;
    if (i_rdy !== 2'b11) begin failures++; $display("FAIL fill_rdy1 got=%b exp=11", i_rdy); end
    send_pkt(1'b1, 1'b1, 16'h0004);
    checks++;
    if (i_rdy !== 2'b01) begin failures++; $display("FAIL fill_rdy2 got=%b exp=01", i_rdy); end
    send_pkt(1'b1, 1'b0, 16'h0005);
    tick;
    checks++;
    if (i_rdy !== 2'b00 || ff_err !== 1'b0 || (qa.size() + qb.size()) != 0)
      begin failures++; $display("FAIL fill_full got rdy=%b err=%b words=%0d exp=00 0 0", i_rdy, ff_err, qa.size() + qb.size()); end
    oa_rdy = 2'b11; ob_rdy = 2'b11;
    for (int n = 0; n < 80 && !(qa.size() >= 18 && qb.size() >= 9); n++) tick;
    repeat (3) tick;
    checks++;
    if (qa.size() != 18 || qb.size() != 9)
      begin failures++; $display("FAIL drain_count got a=%0d b=%0d exp=18 9", qa.size(), qb.size()); end
    else begin
      ia = 0; ib = 0; c0 = int'(qa[0].cyc);
      for (int k = 0; k < 27; k++) begin
        pk = k / 9; wi = k % 9; dst = (pk == 1); tag = 16'(3 + pk);
        exp_d = (wi == 0) ? hdr(1'b1, dst, tag) : pay(tag, wi);
        if (dst) begin w = qb[ib]; ib++; end else begin w = qa[ia]; ia++; end
        checks++;
        if (w.data !== exp_d || w.sof !== (wi == 0) || w.cyc !== 32'(c0 + k))
          begin failures++; $display("FAIL drain_word%0d got d=%h sof=%b cyc=%0d exp d=%h sof=%b cyc=%0d", k, w.data, w.sof, w.cyc, exp_d, wi == 0, c0 + k); end
      end
    end
    checks++;
    if (i_rdy !== 2'b11) begin failures++; $display("FAIL drain_rdy got=%b exp=11", i_rdy); end
  endtask

  task automatic test_alternating;
    int ia, ib, pk, wi, c0;
    logic dst;
    logic [15:0] tag;
    logic [71:0] exp_d;
    word_t w;
    oa_rdy = 2'b11; ob_rdy = 2'b11;
    qa.delete(); qb.delete();
    send_pkt(1'b0, 1'b0, 16'h0006);
    send_pkt(1'b0, 1'b1, 16'h0007);
    send_pkt(1'b0, 1'b0, 16'h0008);
    send_pkt(1'b0, 1'b1, 16'h0009);
    for (int n = 0; n < 40 && !(qa.size() >= 4 && qb.size() >= 4); n++) tick;
    repeat (3) tick;
    checks++;
    if (qa.size() != 4 || qb.size() != 4)
      begin failures++; $display("FAIL alt_count got a=%0d b=%0d exp=4 4", qa.size(), qb.size()); end
    else begin
      ia = 0; ib = 0; c0 = int'(qa[0].cyc);
      for (int k = 0; k < 8; k++) begin
        pk = k / 2; wi = k % 2; dst = (pk % 2 == 1); tag = 16'(6 + pk);
        exp_d = (wi == 0) ? hdr(1'b0, dst, tag) : pay(tag, wi);
        if (dst) begin w = qb[ib]; ib++; end else begin w = qa[ia]; ia++; end
        checks++;
        if (w.data !== exp_d || w.sof !== (wi == 0) || w.cyc !== 32'(c0 + k))
          begin failures++; $display("FAIL alt_word%0d got d=%h sof=%b cyc=%0d exp d=%h sof=%b cyc=%0d", k, w.data, w.sof, w.cyc, exp_d, wi == 0, c0 + k); end
      end
    end
  endtask

`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
  task automatic test_proto_truncate;
    oa_rdy = 2'b11; ob_rdy = 2'b11;
    qa.delete(); qb.delete();
    checks++;
    if (ff_err !== 1'b0) begin failures++; $display("FAIL proto_err_before got=%b exp=0", ff_err); end
    i_stb = 1'b1; i_sof = 1'b1; i_data = hdr(1'b1, 1'b0, 16'h000A);
    tick;
    i_sof = 1'b0; i_data = pay(16'h000A, 1);
    tick;
    send_pkt(1'b0, 1'b0, 16'h000B);
    for (int n = 0; n < 30 && qa.size() < 2; n++) tick;
    repeat (6) tick;
    checks++;
    if (ff_err !== 1'b1) begin failures++; $display("FAIL proto_err got=%b exp=1", ff_err); end
    checks++;
    if (qa.size() != 2 || qb.size() != 0)
      begin failures++; $display("FAIL proto_count got a=%0d b=%0d exp=2 0", qa.size(), qb.size()); end
    else begin
      checks++;
      if (qa[0].data !== hdr(1'b0, 1'b0, 16'h000B) || qa[0].sof !== 1'b1 || qa[1].data !== pay(16'h000B, 1) || qa[1].sof !== 1'b0 || qa[1].cyc !== qa[0].cyc + 32'd1)
        begin failures++; $display("FAIL proto_pkt got %h/%b %h/%b exp %h/1 %h/0", qa[0].data, qa[0].sof, qa[1].data, qa[1].sof, hdr(1'b0, 1'b0, 16'h000B), pay(16'h000B, 1)); end
    end
    checks++;
    if (i_rdy !== 2'b11) begin failures++; $display("FAIL proto_rdy got=%b exp=11", i_rdy); end
  endtask
`endif

  task automatic test_reset_mid_send;
    logic found;
    oa_rdy = 2'b11; ob_rdy = 2'b11;
    send_pkt(1'b1, 1'b1, 16'h000C);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick;
      if (ob_stb === 1'b1 && ob_sof === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_hdr_timeout got=0 exp=1"); end
    repeat (3) tick;
    checks++;
    if (ob_stb !== 1'b1 || ob_data !== pay(16'h000C, 3))
      begin failures++; $display("FAIL mid_word4 got stb=%b d=%h exp=1 %h", ob_stb, ob_data, pay(16'h000C, 3)); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({oa_stb, ob_stb, oa_sof, ob_sof} !== 4'b0 || ob_data !== 72'h0 || i_rdy !== 2'b00)
      begin failures++; $display("FAIL mid_async got flags=%b d=%h rdy=%b exp=0000 0 00", {oa_stb, ob_stb, oa_sof, ob_sof}, ob_data, i_rdy); end
    repeat (2) tick;
    rst = 1'b0;
    tick;
    checks++;
    if (i_rdy !== 2'b11 || ff_err !== 1'b0)
      begin failures++; $display("FAIL mid_release got rdy=%b err=%b exp=11 0", i_rdy, ff_err); end
    qa.delete(); qb.delete();
    repeat (15) tick;
    checks++;
    if (qa.size() != 0 || qb.size() != 0)
      begin failures++; $display("FAIL mid_no_output got a=%0d b=%0d exp=0 0", qa.size(), qb.size()); end
    send_pkt(1'b0, 1'b1, 16'h000D);
    for (int n = 0; n < 20 && qb.size() < 2; n++) tick;
    checks++;
    if (qb.size() < 1 || qb[0].data !== hdr(1'b0, 1'b1, 16'h000D))
      begin failures++; $display("FAIL mid_fifo_empty got words=%0d exp first=%h", qb.size(), hdr(1'b0, 1'b1, 16'h000D)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_short_a;
    test_wait_b;
    test_fill_drain;
    test_alternating;
`ifdef RBUS_DEMUX1TO2_PROTO_CHECK_EN
    test_proto_truncate;
`endif
    test_reset_mid_send;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
